// File: rtl/display_scan_ctrl_pkg.sv
// Shared types, segment glyphs and BCD helpers for the display scan controller.
package disp_pkg;

  localparam int NUM_DIGITS = 4;

  typedef logic [3:0] bcd_digit_t;

  // Active-low segment patterns, bit order a,b,c,d,e,f,g,dp from MSB to LSB.
  localparam logic [7:0] SEG_0     = 8'h03;
  localparam logic [7:0] SEG_1     = 8'h9F;
  localparam logic [7:0] SEG_2     = 8'h25;
  localparam logic [7:0] SEG_3     = 8'h0D;
  localparam logic [7:0] SEG_4     = 8'h99;
  localparam logic [7:0] SEG_5     = 8'h49;
  localparam logic [7:0] SEG_6     = 8'h41;
  localparam logic [7:0] SEG_7     = 8'h1F;
  localparam logic [7:0] SEG_8     = 8'h01;
  localparam logic [7:0] SEG_9     = 8'h09;
  localparam logic [7:0] SEG_BLANK = 8'hFF;
  localparam logic [7:0] SEG_DASH  = 8'hFD;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    LOAD  = 2'd2
  } conv_state_t;

  // One double-dabble step: add 3 to every nibble >= 5, then shift in the next binary bit.
  function automatic logic [19:0] dabble_step(input logic [19:0] bcd, input logic in_bit);
    logic [19:0] adj;
    adj = bcd;
    for (int i = 0; i < 5; i++) begin
      if (adj[i*4 +: 4] >= 4'd5) begin
        adj[i*4 +: 4] = adj[i*4 +: 4] + 4'd3;
      end else begin
        adj[i*4 +: 4] = adj[i*4 +: 4];
      end
    end
    return {adj[18:0], in_bit};
  endfunction

  // Decimal glyph for one BCD digit; non-decimal codes render blank.
  function automatic logic [7:0] seg_encode(input bcd_digit_t d);
    logic [7:0] seg;
    case (d)
      4'd0:    seg = SEG_0;
      4'd1:    seg = SEG_1;
      4'd2:    seg = SEG_2;
      4'd3:    seg = SEG_3;
      4'd4:    seg = SEG_4;
      4'd5:    seg = SEG_5;
      4'd6:    seg = SEG_6;
      4'd7:    seg = SEG_7;
      4'd8:    seg = SEG_8;
      4'd9:    seg = SEG_9;
      default: seg = SEG_BLANK;
    endcase
    return seg;
  endfunction

endpackage

// File: rtl/display_scan_ctrl_if.sv
// Value handshake between the counter datapath (master) and the display controller (slave).
interface display_scan_ctrl_if;
  logic [15:0] value_in;
  logic        value_valid;
  logic        value_ready;

  modport master (output value_in, output value_valid, input value_ready);
  modport slave  (input value_in, input value_valid, output value_ready);
endinterface

// File: rtl/display_scan_ctrl_bin2bcd_seq.sv
// Multi-cycle binary-to-BCD converter: accepts a 16-bit value, runs 16 double-dabble
// steps, then raises a one-cycle load strobe with the 4-digit result and overflow flag.
module bin2bcd_seq
  import disp_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] value_i,
  input  logic        valid_i,
  output logic        ready_o,
  output logic [15:0] bcd_o,
  output logic        overflow_o,
  output logic        load_o
);

  conv_state_t state_q;
  logic [15:0] bin_q;
  logic [19:0] bcd_q;
  logic [3:0]  cnt_q;
  logic        ready_q;
  logic        ovf_q;
  logic        load_q;

  // Conversion sequencer: capture in IDLE, 16 shift steps, one-cycle commit in LOAD.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      bin_q   <= 16'd0;
      bcd_q   <= 20'd0;
      cnt_q   <= 4'd0;
      ready_q <= 1'b1;
      ovf_q   <= 1'b0;
      load_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (valid_i && ready_q) begin
            bin_q   <= value_i;
            bcd_q   <= 20'd0;
            cnt_q   <= 4'd0;
            ovf_q   <= (value_i > 16'd9999);
            ready_q <= 1'b0;
            state_q <= SHIFT;
          end
        end
        SHIFT: begin
          bcd_q <= dabble_step(bcd_q, bin_q[15]);
          bin_q <= {bin_q[14:0], 1'b0};
          cnt_q <= cnt_q + 4'd1;
          if (cnt_q == 4'd15) begin
            load_q  <= 1'b1;
            state_q <= LOAD;
          end
        end
        LOAD: begin
          load_q  <= 1'b0;
          ready_q <= 1'b1;
          state_q <= IDLE;
        end
        default: begin
          load_q  <= 1'b0;
          ready_q <= 1'b1;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign ready_o    = ready_q;
  assign bcd_o      = bcd_q[15:0];
  assign overflow_o = ovf_q;
  assign load_o     = load_q;

endmodule

// File: rtl/display_scan_ctrl.sv
// 4-digit multiplexed seven-segment driver: converts incoming binary values to BCD,
// commits them atomically, and scans the digits with blanking and leading-zero suppression.
module display_scan_ctrl
  import disp_pkg::*;
#(
  parameter int REFRESH_DIV  = 100000,
  parameter int BLANK_CYCLES = 1000,
  parameter int LZ_SUPPRESS  = 1
)
(
  input  logic                 clk,
  input  logic                 rst_n,
  display_scan_ctrl_if.slave   bus,
  output logic [0:3]           digit,
  output logic [0:7]           Seven_Seg
);

  localparam int SLOT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(REFRESH_DIV - 1);
  localparam logic [SLOT_W-1:0] BLANK_LIM = SLOT_W'(BLANK_CYCLES);

  logic [15:0] bcd_s;
  logic        ovf_s;
  logic        load_s;

  logic [15:0]       disp_q;
  logic              ovf_q;
  logic [SLOT_W-1:0] slot_q;
  logic [1:0]        idx_q;
  logic [0:3]        digit_q;
  logic [7:0]        seg_q;

  bcd_digit_t  cur_digit_d;
  logic        lz_blank_d;
  logic [0:3]  digit_d;
  logic [7:0]  seg_d;

  bin2bcd_seq u_conv (
    .clk        (clk),
    .rst_n      (rst_n),
    .value_i    (bus.value_in),
    .valid_i    (bus.value_valid),
    .ready_o    (bus.value_ready),
    .bcd_o      (bcd_s),
    .overflow_o (ovf_s),
    .load_o     (load_s)
  );

  // Display register and overflow flag change together so a scan never shows mixed values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      disp_q <= 16'h0000;
      ovf_q  <= 1'b0;
    end else if (load_s) begin
      ovf_q <= ovf_s;
      if (!ovf_s) begin
        disp_q <= bcd_s;
      end
    end
  end

  // Slot counter sets the per-digit dwell time; the digit index advances on each wrap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot_q <= '0;
      idx_q  <= 2'd0;
    end else if (slot_q == SLOT_LAST) begin
      slot_q <= '0;
      idx_q  <= idx_q + 2'd1;
    end else begin
      slot_q <= slot_q + 1'b1;
    end
  end

  // Pick the digit under scan and decide whether it is a suppressible leading zero.
  always_comb begin
    cur_digit_d = disp_q[3:0];
    lz_blank_d  = 1'b0;
    case (idx_q)
      2'd0: begin
        cur_digit_d = disp_q[15:12];
        lz_blank_d  = (disp_q[15:12] == 4'd0);
      end
      2'd1: begin
        cur_digit_d = disp_q[11:8];
        lz_blank_d  = (disp_q[15:8] == 8'd0);
      end
      2'd2: begin
        cur_digit_d = disp_q[7:4];
        lz_blank_d  = (disp_q[15:4] == 12'd0);
      end
      2'd3: begin
        cur_digit_d = disp_q[3:0];
        lz_blank_d  = 1'b0;
      end
      default: begin
        cur_digit_d = disp_q[3:0];
        lz_blank_d  = 1'b0;
      end
    endcase
  end

  // Next pin values: all off during the anti-ghosting window, else one digit and its glyph.
  always_comb begin
    digit_d = 4'b1111;
    seg_d   = SEG_BLANK;
    if (slot_q < BLANK_LIM) begin
      digit_d = 4'b1111;
      seg_d   = SEG_BLANK;
    end else begin
      digit_d[idx_q] = 1'b0;
      if (ovf_q) begin
        seg_d = SEG_DASH;
      end else if ((LZ_SUPPRESS != 0) && lz_blank_d) begin
        seg_d = SEG_BLANK;
      end else begin
        seg_d = seg_encode(cur_digit_d);
      end
    end
  end

  // Pin registers; reset forces every digit and segment off immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      digit_q <= 4'b1111;
      seg_q   <= SEG_BLANK;
    end else begin
      digit_q <= digit_d;
      seg_q   <= seg_d;
    end
  end

  assign digit     = digit_q;
  assign Seven_Seg = seg_q;

endmodule

// File: tb/tb_display_scan_ctrl.sv
// Scoreboard bench for display_scan_ctrl: two instances (leading-zero suppression on/off)
// receive identical stimulus; a negedge monitor checks every scanned pin cycle.
module tb_display_scan_ctrl;

  typedef struct packed {
    logic [31:0] lz1;   // glyphs digit0..digit3, suppression on
    logic [31:0] lz0;   // glyphs digit0..digit3, suppression off
  } exp_t;

  logic       clk;
  logic       rst_n;
  logic [0:3] dig1, dig0;
  logic [0:7] seg1, seg0;

  display_scan_ctrl_if if_lz1();
  display_scan_ctrl_if if_lz0();

  display_scan_ctrl #(.REFRESH_DIV(8), .BLANK_CYCLES(2), .LZ_SUPPRESS(1)) dut_lz1 (
    .clk(clk), .rst_n(rst_n), .bus(if_lz1), .digit(dig1), .Seven_Seg(seg1)
  );

  display_scan_ctrl #(.REFRESH_DIV(8), .BLANK_CYCLES(2), .LZ_SUPPRESS(0)) dut_lz0 (
    .clk(clk), .rst_n(rst_n), .bus(if_lz0), .digit(dig0), .Seven_Seg(seg0)
  );

  exp_t exp_q[$];
  exp_t cur, nxt;
  bit   pending;
  int   k;
  int   n_checks, n_fail;
  int   pushes, completions;
  int   low_cnt;
  logic prev_ready;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Bench copy of the scan position: posedges since reset release.
  always @(posedge clk) begin
    if (!rst_n) k = 0;
    else        k = k + 1;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic check_pins(input string name, input logic [0:3] dg, input logic [0:7] sg,
                            input logic [31:0] e, input int kk);
    logic [0:3] ed;
    logic [0:7] es;
    int p, slot, idx;
    ed = 4'b1111;
    es = 8'hFF;
    if (kk > 0) begin
      p    = kk - 1;
      slot = p % 8;
      idx  = (p / 8) % 4;
      if (slot >= 2) begin
        ed[idx] = 1'b0;
        es = e[31 - 8*idx -: 8];
      end
    end
    n_checks++;
    if (dg !== ed || sg !== es) begin
      n_fail++;
      $display("FAIL scan_%s k=%0d: digit=%b seg=%h, expected digit=%b seg=%h",
               name, kk, dg, sg, ed, es);
    end
  endtask

  // Monitor: compares pins every cycle and retires one expectation per completed conversion.
  always @(negedge clk) begin
    if (!rst_n) begin
      cur        = {32'hFFFFFF03, 32'h03030303};
      pending    = 1'b0;
      low_cnt    = 0;
      prev_ready = 1'b1;
    end else begin
      if (pending) begin
        cur     = nxt;
        pending = 1'b0;
      end
      check_pins("lz1", dig1, seg1, cur.lz1, k);
      check_pins("lz0", dig0, seg0, cur.lz0, k);
      if (!if_lz1.value_ready) low_cnt++;
      if (if_lz1.value_ready && !prev_ready) begin
        completions++;
        chk("busy_cycles", low_cnt, 17);
        low_cnt = 0;
        n_checks++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_completion: got a completion, expected none queued");
        end else begin
          nxt     = exp_q.pop_front();
          pending = 1'b1;
        end
      end
      prev_ready = if_lz1.value_ready;
    end
  end

  // Present a value, wait (bounded) for acceptance, queue its expected display.
  task automatic issue(input logic [15:0] v, input exp_t e, input bit drop);
    int waited;
    waited = 0;
    if_lz1.value_in = v;  if_lz0.value_in = v;
    if_lz1.value_valid = 1'b1;  if_lz0.value_valid = 1'b1;
    while (if_lz1.value_ready !== 1'b1 && waited < 100) begin
      @(posedge clk); #1;
      waited++;
    end
    n_checks++;
    if (waited >= 100) begin
      n_fail++;
      $display("FAIL accept_timeout value=%0d: ready=%b after %0d cycles, expected 1",
               v, if_lz1.value_ready, waited);
    end else begin
      @(posedge clk); #1;
      exp_q.push_back(e);
      pushes++;
    end
    if (drop) begin
      if_lz1.value_valid = 1'b0;  if_lz0.value_valid = 1'b0;
    end
  endtask

  // Wait (bounded) for the converter to finish, then let a full scan run past the monitor.
  task automatic wait_done();
    int waited;
    waited = 0;
    while (if_lz1.value_ready !== 1'b1 && waited < 100) begin
      @(posedge clk); #1;
      waited++;
    end
    chk("done_timeout", {31'd0, (waited < 100)}, 32'd1);
    repeat (40) @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int w;
    n_checks = 0; n_fail = 0; pushes = 0; completions = 0;
    rst_n = 1'b0;
    if_lz1.value_in = 16'd0;  if_lz0.value_in = 16'd0;
    if_lz1.value_valid = 1'b0; if_lz0.value_valid = 1'b0;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("reset_digit", {28'd0, dig1}, 32'hF);
    chk("reset_seg", {24'd0, seg1}, 32'hFF);
    chk("reset_ready", {31'd0, if_lz1.value_ready}, 32'd1);
    #1 rst_n = 1'b1;

    // Idle after reset: "   0" / "0000"
    repeat (40) @(posedge clk);
    #1;
    chk("idle_ready", {31'd0, if_lz1.value_ready}, 32'd1);

    issue(16'd1234,  {32'h9F250D99, 32'h9F250D99}, 1'b1); wait_done();
    issue(16'd7,     {32'hFFFFFF1F, 32'h0303031F}, 1'b1); wait_done();
    issue(16'd405,   {32'hFF990349, 32'h03990349}, 1'b1); wait_done();
    issue(16'd65535, {32'hFDFDFDFD, 32'hFDFDFDFD}, 1'b1); wait_done();
    issue(16'd9999,  {32'h09090909, 32'h09090909}, 1'b1); wait_done();
    issue(16'd10000, {32'hFDFDFDFD, 32'hFDFDFDFD}, 1'b1); wait_done();

    // Valid held through busy: second value only taken once ready returns
    issue(16'd4321,  {32'h990D259F, 32'h990D259F}, 1'b0);
    issue(16'd5555,  {32'h49494949, 32'h49494949}, 1'b1);
    wait_done();

    // Reset in the middle of a conversion
    issue(16'd8888, {32'h01010101, 32'h01010101}, 1'b1);
    repeat (6) @(posedge clk);
    w = 0;
    while (dig1 === 4'b1111 && w < 4) begin
      @(posedge clk);
      w++;
    end
    #1;
    chk("busy_before_reset", {31'd0, if_lz1.value_ready}, 32'd0);
    chk("lit_before_reset", {31'd0, (dig1 !== 4'b1111)}, 32'd1);
    #1 rst_n = 1'b0;
    #1;
    chk("midreset_digit_lz1", {28'd0, dig1}, 32'hF);
    chk("midreset_seg_lz1", {24'd0, seg1}, 32'hFF);
    chk("midreset_digit_lz0", {28'd0, dig0}, 32'hF);
    chk("midreset_ready", {31'd0, if_lz1.value_ready}, 32'd1);
    void'(exp_q.pop_back());
    pushes--;
    @(posedge clk);
    #2 rst_n = 1'b1;
    repeat (40) @(posedge clk);
    #1;
    chk("ready_after_reset", {31'd0, if_lz1.value_ready}, 32'd1);
    chk("queue_empty", exp_q.size(), 32'd0);
    chk("completions", completions, pushes);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
